// File: rtl/rtlmem_1rw_arb_if.sv
// Bundle of requester, clear-control and single-port memory signals for rtlmem_1rw_arb.
// slave = arbiter view, master = client/memory environment view.
interface rtlmem_1rw_arb_if #(
    parameter int G_ADDR  = 10,
    parameter int G_WIDTH = 16
);
    logic               clr_req;
    logic               clr_busy;

    logic               r0_req;
    logic               r0_we;
    logic [G_ADDR-1:0]  r0_ad;
    logic [G_WIDTH-1:0] r0_di;
    logic               r0_gnt;
    logic               r0_vld;
    logic [G_WIDTH-1:0] r0_do;

    logic               r1_req;
    logic               r1_we;
    logic [G_ADDR-1:0]  r1_ad;
    logic [G_WIDTH-1:0] r1_di;
    logic               r1_gnt;
    logic               r1_vld;
    logic [G_WIDTH-1:0] r1_do;

    logic               mem_clren;
    logic               mem_clrrdy;
    logic [G_ADDR-1:0]  memad;
    logic               memwe;
    logic [G_WIDTH-1:0] memdi;
    logic               memre;
    logic [G_WIDTH-1:0] memdo;

    modport slave (
        input  clr_req, mem_clrrdy, memdo,
        input  r0_req, r0_we, r0_ad, r0_di,
        input  r1_req, r1_we, r1_ad, r1_di,
        output clr_busy, mem_clren, memad, memwe, memdi, memre,
        output r0_gnt, r0_vld, r0_do,
        output r1_gnt, r1_vld, r1_do
    );

    modport master (
        output clr_req, mem_clrrdy, memdo,
        output r0_req, r0_we, r0_ad, r0_di,
        output r1_req, r1_we, r1_ad, r1_di,
        input  clr_busy, mem_clren, memad, memwe, memdi, memre,
        input  r0_gnt, r0_vld, r0_do,
        input  r1_gnt, r1_vld, r1_do
    );
endinterface

// File: rtl/rtlmem_1rw_arb.sv
// Two-requester arbiter for a single-port, 1-cycle-latency memory with clear sequencing.
//   state | meaning
//   IDLE  | normal operation, grants allowed
//   CLR   | one-cycle mem_clren pulse to the memory
//   WAIT  | clear running; first cycle ignores mem_clrrdy, then wait for it
module rtlmem_1rw_arb #(
    parameter int    G_ADDR  = 10,
    parameter int    G_WIDTH = 16,
    parameter string G_PRIO  = "RR"
) (
    input  logic              clk,
    input  logic              rst_n,
    rtlmem_1rw_arb_if.slave   bus
);
    localparam bit FIX0 = (G_PRIO == "FIX0");

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               wait_first_q, wait_first_d;
    logic               rr_last_q, rr_last_d;
    logic [1:0]         rd_own_q, rd_own_d;

    logic               gate_ok;
    logic               pick0;
    logic               gnt0, gnt1;
    logic [G_ADDR-1:0]  memad_d;
    logic [G_WIDTH-1:0] memdi_d;
    logic               memwe_d, memre_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wait_first_q <= 1'b0;
            rr_last_q    <= 1'b1;
            rd_own_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_first_q <= wait_first_d;
            rr_last_q    <= rr_last_d;
            rd_own_q     <= rd_own_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_first_d = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.clr_req) state_d = ST_CLR;
            ST_CLR: begin
                state_d      = ST_WAIT;
                wait_first_d = 1'b1;
            end
            // mem_clrrdy may still show the pre-clear value in the first WAIT cycle
            ST_WAIT: if (!wait_first_q && bus.mem_clrrdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.clr_busy  = (state_q != ST_IDLE);
    assign bus.mem_clren = (state_q == ST_CLR);

    // A pending clr_req beats requests in IDLE; requests simply stay pending.
    assign gate_ok = (state_q == ST_IDLE) && !bus.clr_req && bus.mem_clrrdy;
    assign pick0   = bus.r0_req && (!bus.r1_req || FIX0 || rr_last_q);
    assign gnt0    = gate_ok && pick0;
    assign gnt1    = gate_ok && bus.r1_req && !pick0;

    assign bus.r0_gnt = gnt0;
    assign bus.r1_gnt = gnt1;

    always_comb begin
        rr_last_d = rr_last_q;
        if (gnt0)      rr_last_d = 1'b0;
        else if (gnt1) rr_last_d = 1'b1;
    end

    always_comb begin
        memad_d = '0;
        memdi_d = '0;
        memwe_d = 1'b0;
        memre_d = 1'b0;
        if (gnt0) begin
            memad_d = bus.r0_ad;
            memdi_d = bus.r0_di;
            memwe_d = bus.r0_we;
            memre_d = !bus.r0_we;
        end else if (gnt1) begin
            memad_d = bus.r1_ad;
            memdi_d = bus.r1_di;
            memwe_d = bus.r1_we;
            memre_d = !bus.r1_we;
        end
    end

    assign bus.memad = memad_d;
    assign bus.memdi = memdi_d;
    assign bus.memwe = memwe_d;
    assign bus.memre = memre_d;

    assign rd_own_d   = {gnt1 && !bus.r1_we, gnt0 && !bus.r0_we};
    assign bus.r0_vld = rd_own_q[0];
    assign bus.r1_vld = rd_own_q[1];
    assign bus.r0_do  = bus.memdo;
    assign bus.r1_do  = bus.memdo;
endmodule

// File: doc/rtlmem_1rw_arb.md
Name: rtlmem_1rw_arb

Overview:
- Two-requester controller for a single-port memory that has one shared read/write port and returns read data one cycle after the access.
- Arbitrates access cycle by cycle (round-robin or fixed priority) and returns read data to the requester that issued the read.
- Sequences the memory's content-clear operation and blocks all requesters while the clear is running.
- Sits between client engines and the single-port memory wrapper.

Parameters:
G_ADDR, 10, memory address width
G_WIDTH, 16, data width
G_PRIO, "RR", "RR" = round-robin; "FIX0" = requester 0 always wins

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clr_req  in  1  one-cycle pulse requesting a memory clear
clr_busy  out  1  high while the clear sequence is active
r0_req  in  1  requester 0 access request, held until granted
r0_we  in  1  1 = write, 0 = read
r0_ad  in  G_ADDR  requester 0 address
r0_di  in  G_WIDTH  requester 0 write data
r0_gnt  out  1  access issued to memory this cycle (combinational)
r0_vld  out  1  read data valid for requester 0
r0_do  out  G_WIDTH  read data
r1_req, r1_we, r1_ad, r1_di, r1_gnt, r1_vld, r1_do  same as requester 0
mem_clren  out  1  memory clear start
mem_clrrdy  in  1  memory clear done / ready
memad  out  G_ADDR  memory address
memwe  out  1  memory write enable
memdi  out  G_WIDTH  memory write data
memre  out  1  memory read enable
memdo  in  G_WIDTH  memory read data (1-cycle latency)

Behaviour:
- Interface: reset is rst_n, synchronous, active-low; clock is clk. All state is updated on posedge clk.
- Reset values:
  - FSM = IDLE; mem_clren = 0; clr_busy = 0.
  - r0_vld = r1_vld = 0; rr_last = 1, so requester 0 wins the first contention.
- Clear FSM states: IDLE, CLR, WAIT.
  - IDLE -> CLR when clr_req = 1.
  - CLR lasts exactly one cycle with mem_clren = 1, then moves to WAIT.
  - WAIT ignores mem_clrrdy in its first cycle. It then stays in WAIT until mem_clrrdy = 1, and returns to IDLE.
  - Memory contract: mem_clrrdy is low from the cycle after mem_clren is sampled until the clear completes.
  - clr_busy = (state != IDLE).
  - clr_req in CLR or WAIT is ignored; it is neither queued nor restarted.
- Grant gating: no grant is issued when state != IDLE, when clr_req = 1, or when mem_clrrdy = 0.
  - If clr_req and requests coincide in IDLE, the clear wins and the requests stay pending.
- Arbitration:
  - Only one grant per cycle, to a requester with rN_req = 1.
  - "RR": if both request, grant the port other than rr_last. rr_last is updated to the granted port on each grant.
  - A single requester is granted whenever gating allows.
  - "FIX0": requester 0 always wins; rr_last is unused.
- Memory drive for the granted port N (combinational):
  - memad = rN_ad; memdi = rN_di; memwe = rN_we; memre = ~rN_we.
  - With no grant: memwe = 0, memre = 0, memad and memdi = 0.
- Read return:
  - Registered rd_own = {gnt1 & ~r1_we, gnt0 & ~r0_we}.
  - rN_vld = rd_own[N] exactly one cycle after the granted read.
  - r0_do = r1_do = memdo (broadcast); only the vld qualifies it.
  - Back-to-back reads give consecutive vld pulses, with throughput 1 access per cycle.
- A read granted in the cycle before clr_req still returns its vld.
- Writes never produce vld.
- Write-then-read of the same address in consecutive cycles returns the new data (memory is write-first).
- Reset mid-clear: FSM goes to IDLE, mem_clren = 0, vld flags are cleared, and in-flight read returns are discarded.

Test Plan:
- Single read: r0_req = 1, we = 0, ad = 0x005 after a prior write of 0xBEEF to 0x005 -> r0_gnt in the same cycle; next cycle r0_vld = 1, r0_do = 0xBEEF, r1_vld = 0.
- Contention in RR: r0 and r1 both hold reads for 4 cycles -> grants alternate 0,1,0,1 from reset; vld pulses alternate with 1-cycle lag; memre = 1 every cycle.
- FIX0 starvation: same stimulus with G_PRIO = "FIX0" -> r0_gnt every cycle and r1_gnt = 0 until r0_req drops.
- Clear sequence:
  - clr_req pulse with r1_req held -> mem_clren = 1 for exactly one cycle; clr_busy = 1 and r1_gnt = 0 until mem_clrrdy returns 1.
  - r1 is granted the cycle after the FSM re-enters IDLE.
  - A read of any address afterwards returns 0x0000.
- Collision: clr_req = 1 in the same cycle as r0_req -> r0_gnt = 0, and the clear starts next cycle.
  - A read granted one cycle before clr_req still gives r0_vld = 1.
- Reset mid-WAIT: rst_n = 0 for 1 cycle -> clr_busy = 0, mem_clren = 0, all vld = 0, and the FSM is IDLE on the following edge.
